// File: rtl/counter_sequencer.sv
// counter_sequencer: push-button driven run/pause/step sequencer for a counter
// datapath. Raw inputs are synchronized and debounced; a button press walks
// IDLE -> RUN -> PAUSE -> (RUN | STEP), a prescaler paces ctr_en in RUN, and
// run_ticks counts the strobes issued since the last clear.
// Optional feature: define COUNTER_SEQUENCER_LONGPRESS_EN to build the
// long-press abort (button held HOLD_CYCLES in RUN/PAUSE forces IDLE + clear).
module counter_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PRESCALE        = 1000,
    parameter int HOLD_CYCLES     = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_raw,
    input  logic        sw_raw,
    input  logic        en_in,
    output logic        ctr_en,
    output logic        ctr_clr,
    output logic [1:0]  state,
    output logic [15:0] run_ticks
);

    localparam logic [1:0]  IDLE  = 2'b00;
    localparam logic [1:0]  RUN   = 2'b01;
    localparam logic [1:0]  PAUSE = 2'b10;
    localparam logic [1:0]  STEP  = 2'b11;
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] PS_LAST = 24'(PRESCALE - 1);

    logic [1:0]       btn_sync, sw_sync, en_sync;
    logic [1:0]       deb;          // [0] = button, [1] = switch
    logic [1:0][15:0] db_cnt;
    logic [1:0]       synced;
    logic             btn_deb_q;
    logic             press;
    logic             long_press;
    logic             en_s;
    logic             sw_deb;
    logic [23:0]      presc;
    logic [1:0]       state_nxt;
    logic             clr_nxt;
    logic             clr_q;

    assign synced = {sw_sync[1], btn_sync[1]};
    assign en_s   = en_sync[1];
    assign sw_deb = deb[1];
    assign press  = deb[0] & ~btn_deb_q;

    // Two-flop synchronizers for the asynchronous inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_sync <= '0;
            sw_sync  <= '0;
            en_sync  <= '0;
        end else begin
            btn_sync <= {btn_sync[0], btn_raw};
            sw_sync  <= {sw_sync[0], sw_raw};
            en_sync  <= {en_sync[0], en_in};
        end
    end

    // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb    <= '0;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (synced[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Delayed debounced button for rising-edge (press) detection.
    always_ff @(posedge clk) begin
        if (!rst_n) btn_deb_q <= 1'b0;
        else        btn_deb_q <= deb[0];
    end

`ifdef COUNTER_SEQUENCER_LONGPRESS_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    logic [HW-1:0] hold_cnt;
    logic          hold_cond;

    assign hold_cond  = deb[0] && (state == RUN || state == PAUSE);
    assign long_press = hold_cond && (hold_cnt == HW'(HOLD_CYCLES - 1));

    // Count consecutive held cycles in RUN/PAUSE; any break restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n || !hold_cond || long_press) hold_cnt <= '0;
        else                                    hold_cnt <= hold_cnt + 1'b1;
    end
`else
    // No hold counter: HOLD_CYCLES has no effect in this build.
    assign long_press = 1'b0;
`endif

    // Prescaler: cleared in IDLE, counts in RUN when enabled, otherwise holds.
    // A transition in the same cycle wins over the terminal count.
    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE) begin
            presc <= '0;
        end else if (state == RUN && en_s && !press && !long_press) begin
            presc <= (presc == PS_LAST) ? 24'd0 : presc + 24'd1;
        end
    end

    // FSM state register; the clear strobe is registered so it lands in the
    // first cycle of the new state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            clr_q <= 1'b0;
        end else begin
            state <= state_nxt;
            clr_q <= clr_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        clr_nxt   = 1'b0;
        if (long_press) begin
            state_nxt = IDLE;
            clr_nxt   = 1'b1;
        end else begin
            case (state)
                IDLE: if (press) begin
                    state_nxt = RUN;
                    clr_nxt   = 1'b1;
                end
                RUN:     if (press) state_nxt = PAUSE;
                PAUSE:   if (press) state_nxt = sw_deb ? STEP : RUN;
                default: state_nxt = PAUSE;   // STEP lasts exactly one cycle
            endcase
        end
    end

    // FSM outputs: STEP always strobes; RUN strobes on terminal count unless moving.
    always_comb begin
        ctr_en  = 1'b0;
        ctr_clr = clr_q;
        case (state)
            STEP:    ctr_en = 1'b1;
            RUN:     ctr_en = en_s && (presc == PS_LAST) && !press && !long_press;
            default: ctr_en = 1'b0;
        endcase
    end

    // Strobe counter: clear dominates, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || ctr_clr)                  run_ticks <= '0;
        else if (ctr_en && run_ticks != 16'hFFFF) run_ticks <= run_ticks + 16'd1;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples (range 2..65535) before a debounced level changes.
REQ-002 SHALL have parameter PRESCALE, default 1000, clk cycles between ctr_en pulses in RUN (range 2..2^24-1).
REQ-003 SHALL have parameter HOLD_CYCLES, default 50000, clk cycles of continuous debounced button-high that constitute a long press.
REQ-004 clk  input  1  clock; all logic SHALL sample on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 btn_raw  input  1  asynchronous push-button, active-high.
REQ-007 sw_raw  input  1  asynchronous mode switch; high selects single-step in PAUSE.
REQ-008 en_in  input  1  asynchronous global enable; low freezes prescaler and suppresses ctr_en.
REQ-009 ctr_en  output  1  one-cycle increment strobe to the counter datapath.
REQ-010 ctr_clr  output  1  one-cycle synchronous clear strobe to the counter datapath.
REQ-011 state  output  2  current FSM state code.
REQ-012 run_ticks  output  16  count of ctr_en pulses since last ctr_clr, saturating at 16'hFFFF.

Function
REQ-013 btn_raw, sw_raw and en_in SHALL each pass through a 2-flop synchronizer before any use.
REQ-014 Debounce (btn, sw): per-input counter increments while synced != debounced, clears when equal; debounced level SHALL flip on the cycle the DEBOUNCE_CYCLES-th consecutive differing sample is seen.
REQ-015 press SHALL be a one-cycle pulse in the cycle after debounced btn rises 0->1; a release SHALL NOT generate press.
REQ-016 States: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, STEP=2'b11; state SHALL update on the clk edge following press.
REQ-017 IDLE + press -> RUN, with ctr_clr=1 for exactly the first cycle in RUN and prescaler reset to 0.
REQ-018 RUN + press -> PAUSE; PAUSE + press with debounced sw=0 -> RUN; PAUSE + press with debounced sw=1 -> STEP.
REQ-019 STEP SHALL last exactly one cycle with ctr_en=1 (regardless of en_in), then return to PAUSE.
REQ-020 In RUN with synced en_in=1, prescaler SHALL count 0..PRESCALE-1 and ctr_en SHALL be 1 for one cycle when it equals PRESCALE-1, then wrap to 0.
REQ-021 In RUN with synced en_in=0, prescaler SHALL hold its value and ctr_en SHALL be 0; counting resumes from the held value.
REQ-022 Prescaler SHALL hold in PAUSE/STEP and reset to 0 in IDLE.
REQ-023 Simultaneous press and prescaler terminal count in RUN: transition wins; ctr_en SHALL NOT pulse that cycle and prescaler holds.
REQ-024 run_ticks SHALL increment on every ctr_en=1 cycle, clear to 0 on ctr_clr=1 (clear dominates), and hold at 16'hFFFF once reached.
REQ-025 ctr_en and ctr_clr SHALL never be 1 in the same cycle.

Reset
REQ-026 While rst_n=0 at a clk edge: state=IDLE, ctr_en=0, ctr_clr=0, run_ticks=0, prescaler/debounce/hold counters=0, synchronizer and debounced levels=0.
REQ-027 Reset asserted mid-RUN or mid-STEP SHALL take effect on that edge with no trailing ctr_en pulse; ctr_clr is not asserted by reset.

Configuration
REQ-028 Macro COUNTER_SEQUENCER_LONGPRESS_EN SHALL gate the long-press feature.
REQ-029 Defined: debounced btn high for HOLD_CYCLES consecutive cycles in RUN/PAUSE SHALL force IDLE next edge with ctr_clr=1 for one cycle; the releasing edge SHALL NOT produce press.
REQ-030 Not defined: no hold counter is built; HOLD_CYCLES is ignored; only REQ-017/018 transitions exist.

Verification (bench: DEBOUNCE_CYCLES=4, PRESCALE=8, HOLD_CYCLES=32)
REQ-031 Reset then btn_raw high 10 cycles -> state 00->01, ctr_clr=1 one cycle, then ctr_en every 8th cycle, run_ticks 1,2,3...
REQ-032 btn_raw glitch high for 3 cycles in IDLE -> no press, state stays 00, ctr_clr stays 0.
REQ-033 RUN, en_in low 20 cycles mid-prescale -> no ctr_en, run_ticks constant; en_in high -> next ctr_en after the remaining count.
REQ-034 PAUSE, sw_raw=1, press -> state 11 for one cycle with ctr_en=1, then 10; run_ticks +1.
REQ-035 Press timed to land on prescaler terminal count in RUN -> state 10, no ctr_en, run_ticks unchanged.
REQ-036 With macro defined, btn held 40 cycles in RUN -> state 00, ctr_clr one cycle, run_ticks=0; without macro -> state 10 only.
